// File: rtl/drumbit_pkg.sv
// Shared key-event types and constants for the drum keypad datapath.
// Codes above MAX_KEY_CODE are multi-key aliases from the encoder and are never queued.
package drumbit_pkg;

    localparam int NUM_KEYS   = 20;
    localparam int KEY_CODE_W = 5;

    typedef logic [KEY_CODE_W-1:0] key_code_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        RELEASE = 2'd2
    } keyq_state_t;

    localparam key_code_t MAX_KEY_CODE = key_code_t'(NUM_KEYS - 1);

    function automatic logic code_ok(input key_code_t code);
        return code <= MAX_KEY_CODE;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO of key codes with a registered head entry; push into empty is visible after one edge.
// A push while full is taken only alongside a pop; the head holds while not popped and keeps its last value when empty.
module event_fifo
    import drumbit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  key_code_t                i_push_dat,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output key_code_t                o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    key_code_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W:0]     r_count;
    key_code_t          r_head;

    logic [PTR_W-1:0]   w_rd_nxt;
    logic               w_pop;
    logic               w_wr;

    assign o_full   = (r_count == CNT_FULL);
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_head   = r_head;

    assign w_rd_nxt = r_rd_ptr + 1'b1;
    assign w_pop    = i_pop & ~o_empty;
    // When full, the written slot is the one being popped, so the write is safe.
    assign w_wr     = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Head reloads from the incoming code when it becomes the only entry.
            if (w_wr && (o_empty || (w_pop && r_count == CNT_ONE))) begin
                r_head <= i_push_dat;
            end else if (w_pop && r_count > CNT_ONE) begin
                r_head <= r_mem[w_rd_nxt];
            end
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// One queued event per key press: edge detect, release-count debounce lockout, code range check, FIFO.
// Event visible the cycle after the strobe is seen in IDLE; consumer backpressure via ev_ready, drops flagged sticky.
module key_event_queue
    import drumbit_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int RELEASE_CYCLES = 8,
    parameter int CNT_W          = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [KEY_CODE_W-1:0]    key_code,
    input  logic                     key_strobe,
    output logic                     ev_valid,
    output logic [KEY_CODE_W-1:0]    ev_code,
    input  logic                     ev_ready,
    output logic [$clog2(DEPTH):0]   ev_count,
    output logic                     ev_overflow,
    output logic                     ev_badcode,
    input  logic                     clr_flags
);

    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);

    keyq_state_t        r_state;
    keyq_state_t        w_state_nxt;
    logic [CNT_W-1:0]   r_rel_cnt;
    logic [CNT_W-1:0]   w_rel_cnt_nxt;
    logic               r_overflow;
    logic               r_badcode;

    logic               w_capture;
    logic               w_code_ok;
    logic               w_push_req;
    logic               w_bad_press;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_push_drop;

    assign w_capture   = (r_state == IDLE) & key_strobe;
    assign w_code_ok   = code_ok(key_code);
    assign w_push_req  = w_capture & w_code_ok;
    assign w_bad_press = w_capture & ~w_code_ok;
    assign w_pop       = ev_valid & ev_ready;
    assign w_push_drop = w_push_req & w_full & ~w_pop;

    assign ev_valid    = ~w_empty;
    assign ev_overflow = r_overflow;
    assign ev_badcode  = r_badcode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rel_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rel_cnt <= w_rel_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rel_cnt_nxt = r_rel_cnt;
        case (r_state)
            IDLE: begin
                if (key_strobe) begin
                    w_state_nxt = HELD;
                end
            end
            HELD: begin
                if (!key_strobe) begin
                    w_rel_cnt_nxt = '0;
                    // A single required low cycle is already satisfied by this one.
                    if (RELEASE_CYCLES == 1) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (key_strobe) begin
                    w_rel_cnt_nxt = '0;
                    w_state_nxt   = HELD;
                end else begin
                    w_rel_cnt_nxt = r_rel_cnt + 1'b1;
                    if (w_rel_cnt_nxt == REL_LAST) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_rel_cnt_nxt = '0;
                w_state_nxt   = IDLE;
            end
        endcase
    end

    // A new error in the same cycle as clr_flags takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_badcode  <= 1'b0;
        end else begin
            if (w_push_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_flags) begin
                r_overflow <= 1'b0;
            end
            if (w_bad_press) begin
                r_badcode <= 1'b1;
            end else if (clr_flags) begin
                r_badcode <= 1'b0;
            end
        end
    end

    event_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push_req),
        .i_push_dat (key_code),
        .i_pop      (w_pop),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (ev_count),
        .o_head     (ev_code)
    );

endmodule

// File: tb/tb_key_event_queue.sv
// Scoreboard bench for key_event_queue: stimulus queues expected codes, a negedge monitor checks each handshake.
module tb_key_event_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] key_code;
    logic       key_strobe;
    logic       ev_valid;
    logic [4:0] ev_code;
    logic       ev_ready;
    logic [2:0] ev_count;
    logic       ev_overflow;
    logic       ev_badcode;
    logic       clr_flags;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [4:0] exp_q[$];
    logic [4:0] mon_exp;

    always #5 clk = ~clk;

    key_event_queue #(
        .DEPTH          (4),
        .RELEASE_CYCLES (8),
        .CNT_W          (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_code    (key_code),
        .key_strobe  (key_strobe),
        .ev_valid    (ev_valid),
        .ev_code     (ev_code),
        .ev_ready    (ev_ready),
        .ev_count    (ev_count),
        .ev_overflow (ev_overflow),
        .ev_badcode  (ev_badcode),
        .clr_flags   (clr_flags)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] code, input int hi, input int lo);
        key_code   = code;
        key_strobe = 1'b1;
        repeat (hi) tick();
        key_strobe = 1'b0;
        repeat (lo) tick();
    endtask

    // Monitor: every accepted event must match the oldest expected code.
    always @(negedge clk) begin
        if (!rst && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: got code %0d, expected no event", ev_code);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("ev_code", int'(ev_code), int'(mon_exp));
            end
        end
    end

    initial begin
        rst        = 1'b1;
        key_code   = '0;
        key_strobe = 1'b0;
        ev_ready   = 1'b0;
        clr_flags  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid",    int'(ev_valid),    0);
        chk("rst_code",     int'(ev_code),     0);
        chk("rst_count",    int'(ev_count),    0);
        chk("rst_overflow", int'(ev_overflow), 0);
        chk("rst_badcode",  int'(ev_badcode),  0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Single press, code 7, held 10 cycles
        ev_ready   = 1'b1;
        key_code   = 5'd7;
        key_strobe = 1'b1;
        exp_q.push_back(5'd7);
        @(negedge clk);
        chk("sp_valid_before", int'(ev_valid), 0);
        tick();
        @(negedge clk);
        chk("sp_valid_first", int'(ev_valid), 1);
        tick();
        @(negedge clk);
        chk("sp_valid_after", int'(ev_valid), 0);
        repeat (8) tick();
        key_strobe = 1'b0;
        repeat (12) tick();
        chk("sp_drained", exp_q.size(), 0);

        // Bounce inside the lockout window yields one event
        exp_q.push_back(5'd3);
        press(5'd3, 5, 3);
        press(5'd3, 5, 20);
        chk("bounce_drained", exp_q.size(), 0);
        chk("bounce_count", int'(ev_count), 0);

        // Rate limit: 8 low cycles re-arms, 7 does not
        exp_q.push_back(5'd2);
        exp_q.push_back(5'd9);
        press(5'd2, 4, 8);
        press(5'd9, 4, 20);
        chk("rate8_drained", exp_q.size(), 0);
        exp_q.push_back(5'd2);
        press(5'd2, 4, 7);
        press(5'd9, 4, 20);
        chk("rate7_drained", exp_q.size(), 0);

        // Overflow with consumer stalled
        ev_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(5'(i));
            press(5'(i), 3, 12);
        end
        chk("ovf_count",    int'(ev_count),    4);
        chk("ovf_flag",     int'(ev_overflow), 1);
        chk("ovf_badcode",  int'(ev_badcode),  0);
        ev_ready = 1'b1;
        repeat (6) tick();
        chk("ovf_drained",     exp_q.size(),      0);
        chk("ovf_count_empty", int'(ev_count),    0);
        chk("ovf_sticky",      int'(ev_overflow), 1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("ovf_cleared", int'(ev_overflow), 0);

        // Full FIFO with a pop in the same cycle as a new press
        ev_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(5'(10 + i));
            press(5'(10 + i), 3, 12);
        end
        chk("full_count", int'(ev_count), 4);
        key_code   = 5'd19;
        key_strobe = 1'b1;
        ev_ready   = 1'b1;
        exp_q.push_back(5'd19);
        tick();
        ev_ready = 1'b0;
        @(negedge clk);
        chk("fullpop_count",    int'(ev_count),    4);
        chk("fullpop_overflow", int'(ev_overflow), 0);
        repeat (2) tick();
        key_strobe = 1'b0;
        repeat (12) tick();
        ev_ready = 1'b1;
        repeat (8) tick();
        chk("fullpop_drained", exp_q.size(), 0);
        chk("fullpop_empty",   int'(ev_count), 0);

        // Out-of-range code is discarded and flagged
        press(5'd23, 3, 12);
        chk("bad_flag",  int'(ev_badcode), 1);
        chk("bad_count", int'(ev_count),   0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("bad_cleared", int'(ev_badcode), 0);
        key_code   = 5'd25;
        key_strobe = 1'b1;
        clr_flags  = 1'b1;
        tick();
        clr_flags = 1'b0;
        @(negedge clk);
        chk("bad_set_beats_clr", int'(ev_badcode), 1);
        repeat (2) tick();
        key_strobe = 1'b0;
        repeat (12) tick();

        // Reset while HELD with two events queued
        ev_ready = 1'b0;
        press(5'd5, 3, 12);
        key_code   = 5'd6;
        key_strobe = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk("prerst_count", int'(ev_count), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid",   int'(ev_valid),    0);
        chk("midrst_code",    int'(ev_code),     0);
        chk("midrst_count",   int'(ev_count),    0);
        chk("midrst_badcode", int'(ev_badcode),  0);
        chk("midrst_ovf",     int'(ev_overflow), 0);
        tick();
        rst      = 1'b0;
        ev_ready = 1'b1;
        exp_q.push_back(5'd6);
        tick();
        @(negedge clk);
        chk("postrst_valid", int'(ev_valid), 1);
        repeat (2) tick();
        key_strobe = 1'b0;
        repeat (12) tick();
        chk("postrst_drained", exp_q.size(), 0);
        chk("postrst_count",   int'(ev_count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Downstream consumer of the 20-key scanner/encoder stage, which supplies a 5-bit key code and a level strobe.
- The strobe rises 2 cycles after any key is pressed, stays high while the key is held, and falls 2 cycles after release.
- This block turns each press into exactly one queued event: edge detect, release-based debounce lockout, code range check.
- Events are buffered in a small FIFO and handed to the sequencer control logic over a valid/ready interface.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- RELEASE_CYCLES, 8, consecutive strobe-low cycles required before a new press is accepted; minimum 1.
- CNT_W, 4, width of the release counter; must satisfy 2^CNT_W > RELEASE_CYCLES.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- key_code  in  5  encoded key from the scanner; meaningful only while key_strobe=1.
- key_strobe  in  1  level strobe from the scanner.
- ev_valid  out  1  head-of-queue event available.
- ev_code  out  5  head event code, 0..19.
- ev_ready  in  1  consumer accepts the head event when ev_valid & ev_ready.
- ev_count  out  $clog2(DEPTH)+1  number of queued events.
- ev_overflow  out  1  sticky: a valid event was dropped because the FIFO was full.
- ev_badcode  out  1  sticky: a press with code >19 (multi-key alias) was discarded.
- clr_flags  in  1  synchronous clear of ev_overflow and ev_badcode.

Behaviour:
Reset (async, immediate):
- State = IDLE, FIFO emptied, release counter = 0.
- ev_valid=0, ev_code=0, ev_count=0, ev_overflow=0, ev_badcode=0.
- Reset mid-press: after release, state is IDLE. If key_strobe is still high on the first post-reset edge, that press is captured as a new event.

Debounce FSM, states IDLE, HELD, RELEASE:
- IDLE: key_strobe=1 -> capture key_code this cycle, issue a push request, go HELD.
- HELD: key_strobe=0 -> go RELEASE, counter=0. Otherwise stay; no further pushes.
- RELEASE, key_strobe=1 -> back to HELD. This is a bounce: no event, counter cleared.
- RELEASE, key_strobe=0 -> counter++. When the counter reaches RELEASE_CYCLES-1, go IDLE.
- Net effect: the earliest re-capture is RELEASE_CYCLES+1 cycles after the strobe falls.

Code check on capture:
- key_code <= 19 -> push request.
- key_code >= 20 -> no push; ev_badcode set next cycle; FSM still goes HELD.

FIFO:
- Push accepted if not full, or if full and a pop occurs in the same cycle.
- A push request that is not accepted is dropped, and ev_overflow is set next cycle.
- Pop = ev_valid & ev_ready. Pop when empty is impossible because ev_valid=0.
- Latency: a push into an empty FIFO at edge N gives ev_valid=1 and ev_code valid after edge N. The event is therefore visible the cycle after the strobe is first seen high in IDLE.
- ev_code is the registered head entry. It holds its value while ev_valid & !ev_ready.
- When empty, ev_code holds its last value; the consumer ignores it.
- Simultaneous push and pop: ev_count unchanged; ordering preserved (FIFO order).
- Pointers wrap modulo DEPTH. ev_count saturates only by construction, never exceeding DEPTH.

Flags:
- clr_flags clears both flags. A set event in the same cycle as clr_flags wins, so the flag ends at 1.

Decomposition:
- Shared package drumbit_pkg holds:
  - NUM_KEYS = 20, KEY_CODE_W = 5
  - typedef logic [KEY_CODE_W-1:0] key_code_t
  - typedef enum {IDLE, HELD, RELEASE} keyq_state_t
  - MAX_KEY_CODE = NUM_KEYS-1
- Sub-module event_fifo: synchronous FIFO of key_code_t with push/pop/full/empty/count and registered head output, parameterised by DEPTH.
- key_event_queue holds the FSM, release counter, code check and sticky flags.

Test Plan:
- Single press: strobe high 10 cycles with code 7, ev_ready=1 -> exactly one event, code 7; ev_valid high for exactly 1 cycle, beginning the cycle after the strobe rises.
- Bounce: strobe 1(5), 0(3), 1(5), 0(20), RELEASE_CYCLES=8, code 3 -> exactly one event, code 3.
- Rate limit: two presses with codes 2 then 9, separated by exactly 8 low cycles -> both queued. Same with only 7 low cycles -> only code 2 queued.
- Overflow: ev_ready=0, five well-separated presses, codes 0,1,2,3,4, DEPTH=4 -> ev_count=4, ev_overflow=1. Then drain with ev_ready=1 -> codes 0,1,2,3 in order. Then pulse clr_flags -> ev_overflow=0.
- Full plus simultaneous pop: FIFO full, ev_ready=1 in the same cycle a new press with code 19 arrives -> code 19 accepted, ev_overflow stays 0, ev_count stays 4.
- Bad code and reset: press with code 23 -> no event, ev_badcode=1. Assert rst while HELD with 2 events queued -> all outputs 0 immediately. Strobe still high after rst release -> one new event is captured.
